// File: rtl/ex_stage_pkg.sv
// ex_stage_pkg: shared widths, select/op encodings, FSM states and the
// pass-through field bundle for the execute stage.
package ex_stage_pkg;
    localparam int XLEN = 32;
    localparam int SHW  = $clog2(XLEN);
    typedef logic [XLEN-1:0] word_t;
    localparam logic [1:0] ALU_SEL_ALU    = 2'b01;
    localparam logic [1:0] ALU_SEL_MULDIV = 2'b10;
    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLL,
        ALU_SRL, ALU_SRA, ALU_SLT, ALU_SLTU, ALU_PASS2
    } alu_op_e;
    typedef enum logic [2:0] {
        MD_MUL, MD_MULH, MD_MULHSU, MD_MULHU, MD_DIV, MD_DIVU, MD_REM, MD_REMU
    } md_op_e;
    typedef enum logic [1:0] {MD_IDLE, MD_BUSY, MD_DONE} md_state_e;
    typedef struct packed {
        logic       reg_wen;
        logic [4:0] reg_waddr;
        logic [1:0] wb_sel;
        word_t      pc;
        word_t      pc4;
        logic       mem_wen;
        word_t      mem_wdata;
    } fields_t;
endpackage

// File: rtl/ex_stage_if.sv
// ex_stage_if: ID/EX operand/control bundle in, EX/MEM result bundle out.
interface ex_stage_if;
    import ex_stage_pkg::*;
    logic       inst_valid_i;
    word_t      op1_i;
    word_t      op2_i;
    logic [1:0] alu_sel_i;
    logic [3:0] alu_op_i;
    logic       reg_wen_i;
    logic [4:0] reg_waddr_i;
    logic [1:0] wb_sel_i;
    word_t      pc_i;
    word_t      pc4_i;
    logic       mem_wen_i;
    word_t      mem_wdata_i;
    word_t      alu_result_o;
    logic       inst_valid_o;
    logic       reg_wen_o;
    logic [4:0] reg_waddr_o;
    logic [1:0] wb_sel_o;
    word_t      pc_o;
    word_t      pc4_o;
    logic       mem_wen_o;
    word_t      mem_wdata_o;
    modport slave (
        input  inst_valid_i, op1_i, op2_i, alu_sel_i, alu_op_i, reg_wen_i, reg_waddr_i,
               wb_sel_i, pc_i, pc4_i, mem_wen_i, mem_wdata_i,
        output alu_result_o, inst_valid_o, reg_wen_o, reg_waddr_o, wb_sel_o,
               pc_o, pc4_o, mem_wen_o, mem_wdata_o
    );
    modport master (
        output inst_valid_i, op1_i, op2_i, alu_sel_i, alu_op_i, reg_wen_i, reg_waddr_i,
               wb_sel_i, pc_i, pc4_i, mem_wen_i, mem_wdata_i,
        input  alu_result_o, inst_valid_o, reg_wen_o, reg_waddr_o, wb_sel_o,
               pc_o, pc4_o, mem_wen_o, mem_wdata_o
    );
endinterface

// File: rtl/ex_muldiv.sv
// ex_muldiv: iterative multiply/divide, one shift-add or restoring-divide step
// per cycle on operand magnitudes, sign applied to the final result.
module ex_muldiv
    import ex_stage_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       flush_i,
    input  logic       start_i,
    input  logic [2:0] op_i,
    input  word_t      a_i,
    input  word_t      b_i,
    output logic       busy_o,
    output logic       done_o,
    output word_t      result_o
);
    md_state_e         state_q, state_d;
    logic [SHW-1:0]    cnt_q, cnt_d;
    logic [2:0]        op_q, op_d;
    word_t             hi_q, hi_d, lo_q, lo_d, b_q, b_d;
    logic              neg_q, neg_d, rneg_q, rneg_d;
    logic              a_neg, b_neg;
    logic [XLEN:0]     trial, msum;
    logic [2*XLEN-1:0] prod;
    word_t             quo, rem;

    assign a_neg = a_i[XLEN-1] & (op_i == MD_MULH || op_i == MD_MULHSU || op_i == MD_DIV || op_i == MD_REM);
    assign b_neg = b_i[XLEN-1] & (op_i == MD_MULH || op_i == MD_DIV || op_i == MD_REM);
    assign trial = {hi_q, lo_q[XLEN-1]} - {1'b0, b_q};
    assign msum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        b_d     = b_q;
        neg_d   = neg_q;
        rneg_d  = rneg_q;
        case (state_q)
            MD_IDLE: if (start_i && !flush_i) begin
                state_d = MD_BUSY;
                cnt_d   = '0;
                op_d    = op_i;
                hi_d    = '0;
                lo_d    = a_neg ? -a_i : a_i;
                b_d     = b_neg ? -b_i : b_i;
                // a zero divisor keeps the all-ones quotient unsigned
                neg_d   = (a_neg ^ b_neg) & (!op_i[2] | (|b_i));
                rneg_d  = a_neg;
            end
            MD_BUSY: if (flush_i) state_d = MD_IDLE;
            else begin
                cnt_d   = cnt_q + 1'b1;
                state_d = (cnt_q == SHW'(XLEN - 1)) ? MD_DONE : MD_BUSY;
                if (op_q[2]) begin
                    hi_d = trial[XLEN] ? {hi_q[XLEN-2:0], lo_q[XLEN-1]} : trial[XLEN-1:0];
                    lo_d = {lo_q[XLEN-2:0], !trial[XLEN]};
                end else
                    {hi_d, lo_d} = {msum, lo_q[XLEN-1:1]};
            end
            default: state_d = MD_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state_q <= MD_IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            b_q     <= '0;
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            b_q     <= b_d;
            neg_q   <= neg_d;
            rneg_q  <= rneg_d;
        end

    assign prod     = neg_q ? -{hi_q, lo_q} : {hi_q, lo_q};
    assign quo      = neg_q ? -lo_q : lo_q;
    assign rem      = rneg_q ? -hi_q : hi_q;
    assign result_o = op_q[2] ? (op_q[1] ? rem : quo) : (op_q[1:0] == 2'd0 ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN]);
    assign busy_o   = state_q == MD_BUSY;
    assign done_o   = state_q == MD_DONE;
endmodule

// File: rtl/ex_stage.sv
// ex_stage: single-cycle ALU plus iterative mul/div with pipeline pause.
// Define FAST_MUL_EN to make MUL* single-cycle combinational.
module ex_stage
    import ex_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush_i,
    ex_stage_if.slave   bus,
    output logic        pause_req_o
);
    fields_t        fld_in, fld_q, fld_d, fld_out;
    logic           is_md, go_md, start, bubble, md_busy, md_done;
    word_t          alu_res, md_comb, md_res, comb_res;
    logic [SHW-1:0] sh;

    assign fld_in = {bus.reg_wen_i, bus.reg_waddr_i, bus.wb_sel_i, bus.pc_i, bus.pc4_i, bus.mem_wen_i, bus.mem_wdata_i};
    assign sh     = bus.op2_i[SHW-1:0];
    assign is_md  = bus.alu_sel_i == ALU_SEL_MULDIV && !bus.alu_op_i[3];

    always_comb begin
        alu_res = '0;
        case (bus.alu_op_i)
            ALU_ADD:   alu_res = bus.op1_i + bus.op2_i;
            ALU_SUB:   alu_res = bus.op1_i - bus.op2_i;
            ALU_AND:   alu_res = bus.op1_i & bus.op2_i;
            ALU_OR:    alu_res = bus.op1_i | bus.op2_i;
            ALU_XOR:   alu_res = bus.op1_i ^ bus.op2_i;
            ALU_SLL:   alu_res = bus.op1_i << sh;
            ALU_SRL:   alu_res = bus.op1_i >> sh;
            ALU_SRA:   alu_res = word_t'($signed(bus.op1_i) >>> sh);
            ALU_SLT:   alu_res = word_t'($signed(bus.op1_i) < $signed(bus.op2_i));
            ALU_SLTU:  alu_res = word_t'(bus.op1_i < bus.op2_i);
            ALU_PASS2: alu_res = bus.op2_i;
            default:   alu_res = '0;
        endcase
    end

`ifdef FAST_MUL_EN
    logic              fa_s, fb_s;
    logic [2*XLEN-1:0] fprod;
    assign fa_s    = bus.op1_i[XLEN-1] & (bus.alu_op_i[1:0] == 2'd1 || bus.alu_op_i[1:0] == 2'd2);
    assign fb_s    = bus.op2_i[XLEN-1] & (bus.alu_op_i[1:0] == 2'd1);
    assign fprod   = {{XLEN{fa_s}}, bus.op1_i} * {{XLEN{fb_s}}, bus.op2_i};
    assign md_comb = (!is_md || bus.alu_op_i[2]) ? '0 :
                     bus.alu_op_i[1:0] == 2'd0 ? fprod[XLEN-1:0] : fprod[2*XLEN-1:XLEN];
    assign go_md   = is_md & bus.alu_op_i[2];
`else
    assign md_comb = '0;
    assign go_md   = is_md;
`endif

    // only an idle unit may accept; DONE still sees the stalled instruction
    assign start    = rst_n & bus.inst_valid_i & go_md & !flush_i & !md_busy & !md_done;
    assign comb_res = bus.alu_sel_i == ALU_SEL_ALU ? alu_res : md_comb;

    ex_muldiv u_muldiv (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush_i  (flush_i),
        .start_i  (start),
        .op_i     (bus.alu_op_i[2:0]),
        .a_i      (bus.op1_i),
        .b_i      (bus.op2_i),
        .busy_o   (md_busy),
        .done_o   (md_done),
        .result_o (md_res)
    );

    assign fld_d = start ? fld_in : fld_q;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) fld_q <= '0;
        else fld_q <= fld_d;

    assign pause_req_o      = start | (md_busy & !flush_i);
    assign bubble           = flush_i | !rst_n | start | md_busy;
    assign fld_out          = bubble ? '0 : md_done ? fld_q : fld_in;
    assign bus.inst_valid_o = !bubble & (md_done | bus.inst_valid_i);
    assign bus.alu_result_o = bubble ? '0 : md_done ? md_res : comb_res;
    assign bus.reg_wen_o    = fld_out.reg_wen;
    assign bus.reg_waddr_o  = fld_out.reg_waddr;
    assign bus.wb_sel_o     = fld_out.wb_sel;
    assign bus.pc_o         = fld_out.pc;
    assign bus.pc4_o        = fld_out.pc4;
    assign bus.mem_wen_o    = fld_out.mem_wen;
    assign bus.mem_wdata_o  = fld_out.mem_wdata;
endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: vector table, random ops against an arithmetic model, and
// hand sequences for flush and reset around the iterative unit.
module tb_ex_stage;
    import ex_stage_pkg::*;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;
    logic pause;
    int   checks = 0;
    int   errors = 0;

    ex_stage_if bus();
    ex_stage dut (.clk(clk), .rst_n(rst_n), .flush_i(flush), .bus(bus), .pause_req_o(pause));

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] sel;
        logic [3:0] op;
        word_t      a;
        word_t      b;
        word_t      exp;
    } vec_t;

    task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [1:0] sel, input logic [3:0] op, input word_t a, input word_t b);
        bus.inst_valid_i = v;
        bus.alu_sel_i    = sel;
        bus.alu_op_i     = op;
        bus.op1_i        = a;
        bus.op2_i        = b;
        bus.reg_wen_i    = 1'($urandom);
        bus.reg_waddr_i  = 5'($urandom);
        bus.wb_sel_i     = 2'($urandom);
        bus.pc_i         = $urandom;
        bus.pc4_i        = $urandom;
        bus.mem_wen_i    = 1'($urandom);
        bus.mem_wdata_i  = $urandom;
    endtask

    function automatic logic [104:0] pt_in();
        return {bus.reg_wen_i, bus.reg_waddr_i, bus.wb_sel_i, bus.pc_i, bus.pc4_i, bus.mem_wen_i, bus.mem_wdata_i};
    endfunction

    function automatic logic [104:0] pt_out();
        return {bus.reg_wen_o, bus.reg_waddr_o, bus.wb_sel_o, bus.pc_o, bus.pc4_o, bus.mem_wen_o, bus.mem_wdata_o};
    endfunction

    function automatic logic [159:0] outs();
        return 160'({bus.inst_valid_o, pt_out(), bus.alu_result_o, pause});
    endfunction

    function automatic word_t ref_res(input logic [1:0] sel, input logic [3:0] op, input word_t a, input word_t b);
        longint sa, sb, ua, ub, p;
        int     sh;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'(a);
        ub = longint'(b);
        sh = int'(b[4:0]);
        if (sel == 2'd1)
            case (op)
                4'd0:    return a + b;
                4'd1:    return a - b;
                4'd2:    return a & b;
                4'd3:    return a | b;
                4'd4:    return a ^ b;
                4'd5:    return word_t'(ua << sh);
                4'd6:    return word_t'(ua >> sh);
                4'd7:    return word_t'(sa >>> sh);
                4'd8:    return word_t'(sa < sb);
                4'd9:    return word_t'(ua < ub);
                4'd10:   return b;
                default: return '0;
            endcase
        if (sel == 2'd2)
            case (op)
                4'd0: begin p = ua * ub; return p[31:0]; end
                4'd1: begin p = sa * sb; return p[63:32]; end
                4'd2: begin p = sa * ub; return p[63:32]; end
                4'd3: begin p = ua * ub; return p[63:32]; end
                4'd4:    return b == 0 ? '1 : (a == 32'h8000_0000 && b == '1) ? a : word_t'(sa / sb);
                4'd5:    return b == 0 ? '1 : word_t'(ua / ub);
                4'd6:    return b == 0 ? a : (a == 32'h8000_0000 && b == '1) ? '0 : word_t'(sa % sb);
                4'd7:    return b == 0 ? a : word_t'(ua % ub);
                default: return '0;
            endcase
        return '0;
    endfunction

    function automatic int exp_lat(input logic [1:0] sel, input logic [3:0] op);
`ifdef FAST_MUL_EN
        return (sel == 2'd2 && op < 4'd8 && op >= 4'd4) ? XLEN + 1 : 0;
`else
        return (sel == 2'd2 && op < 4'd8) ? XLEN + 1 : 0;
`endif
    endfunction

    function automatic word_t rnd_word();
        case ($urandom_range(0, 4))
            0:       return '0;
            1:       return '1;
            2:       return 32'h8000_0000;
            3:       return word_t'($urandom_range(0, 9));
            default: return word_t'($urandom);
        endcase
    endfunction

    task automatic run_op(input string nm, input logic [1:0] sel, input logic [3:0] op, input word_t a, input word_t b, input word_t exp);
        int lat, c, pc;
        logic found;
        logic [104:0] pt;
        lat = exp_lat(sel, op);
        c = 0;
        pc = 0;
        found = 1'b0;
        @(posedge clk);
        #1;
        flush = 1'b0;
        drive(1'b1, sel, op, a, b);
        pt = pt_in();
        while (!found && c <= 40) begin
            @(negedge clk);
            if (bus.inst_valid_o) found = 1'b1;
            else begin
                pc += int'(pause);
                c++;
            end
        end
        chk({nm, " latency"}, 160'(c), 160'(lat));
        chk({nm, " pause cycles"}, 160'(pc), 160'(lat));
        chk({nm, " pause at result"}, 160'(pause), 160'(0));
        chk({nm, " result"}, 160'(bus.alu_result_o), 160'(exp));
        chk({nm, " passthru"}, 160'(pt_out()), 160'(pt));
    endtask

    task automatic idle_watch(input string nm);
        int v, p;
        v = 0;
        p = 0;
        @(posedge clk);
        #1;
        flush = 1'b0;
        drive(1'b0, 2'd0, 4'd0, '0, '0);
        repeat (40) begin
            @(negedge clk);
            v += int'(bus.inst_valid_o);
            p += int'(pause);
        end
        chk({nm, " stray valid"}, 160'(v), 160'(0));
        chk({nm, " stray pause"}, 160'(p), 160'(0));
    endtask

    initial begin
        vec_t tbl[22];
        tbl[0]  = '{2'd1, 4'd0,  32'd5,          32'd7,          32'd12};
        tbl[1]  = '{2'd1, 4'd7,  32'h8000_0000,  32'd4,          32'hF800_0000};
        tbl[2]  = '{2'd2, 4'd4,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD};
        tbl[3]  = '{2'd2, 4'd6,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF};
        tbl[4]  = '{2'd2, 4'd5,  32'd100,        32'd0,          32'hFFFF_FFFF};
        tbl[5]  = '{2'd2, 4'd7,  32'd100,        32'd0,          32'd100};
        tbl[6]  = '{2'd2, 4'd4,  32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000};
        tbl[7]  = '{2'd2, 4'd6,  32'h8000_0000,  32'hFFFF_FFFF,  32'd0};
        tbl[8]  = '{2'd2, 4'd3,  32'h8000_0000,  32'h8000_0000,  32'h4000_0000};
        tbl[9]  = '{2'd2, 4'd2,  32'hFFFF_FFFF,  32'd2,          32'hFFFF_FFFF};
        tbl[10] = '{2'd1, 4'd1,  32'd3,          32'd5,          32'hFFFF_FFFE};
        tbl[11] = '{2'd1, 4'd8,  32'hFFFF_FFFF,  32'd1,          32'd1};
        tbl[12] = '{2'd1, 4'd9,  32'hFFFF_FFFF,  32'd1,          32'd0};
        tbl[13] = '{2'd2, 4'd0,  32'd7,          32'hFFFF_FFFD,  32'hFFFF_FFEB};
        tbl[14] = '{2'd2, 4'd1,  32'hFFFF_FFFE,  32'd3,          32'hFFFF_FFFF};
        tbl[15] = '{2'd3, 4'd0,  32'd5,          32'd7,          32'd0};
        tbl[16] = '{2'd1, 4'd12, 32'd5,          32'd7,          32'd0};
        tbl[17] = '{2'd1, 4'd5,  32'd1,          32'h23,         32'd8};
        tbl[18] = '{2'd2, 4'd4,  32'hFFFF_FFF9,  32'd0,          32'hFFFF_FFFF};
        tbl[19] = '{2'd2, 4'd6,  32'hFFFF_FFF9,  32'd0,          32'hFFFF_FFF9};
        tbl[20] = '{2'd2, 4'd4,  32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD};
        tbl[21] = '{2'd2, 4'd6,  32'd7,          32'hFFFF_FFFE,  32'd1};

        drive(1'b1, 2'd1, 4'd0, 32'd5, 32'd7);
        #2;
        chk("reset outputs", outs(), 160'(0));
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 22; i++)
            run_op($sformatf("vec%0d", i), tbl[i].sel, tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].exp);

        @(posedge clk);
        #1;
        drive(1'b1, 2'd2, 4'd4, 32'hFFFF_FFF9, 32'd2);
        repeat (10) @(posedge clk);
        #1;
        flush = 1'b1;
        @(negedge clk);
        chk("busy flush pause", 160'(pause), 160'(0));
        chk("busy flush valid", 160'(bus.inst_valid_o), 160'(0));
        idle_watch("busy flush");
        run_op("add after flush", 2'd1, 4'd0, 32'd5, 32'd7, 32'd12);

        @(posedge clk);
        #1;
        drive(1'b1, 2'd2, 4'd5, 32'd50, 32'd5);
        flush = 1'b1;
        @(negedge clk);
        chk("start flush pause", 160'(pause), 160'(0));
        chk("start flush valid", 160'(bus.inst_valid_o), 160'(0));
        idle_watch("start flush");

        @(posedge clk);
        #1;
        drive(1'b1, 2'd2, 4'd5, 32'd50, 32'd5);
        repeat (XLEN + 1) @(posedge clk);
        #1;
        flush = 1'b1;
        @(negedge clk);
        chk("done flush valid", 160'(bus.inst_valid_o), 160'(0));
        chk("done flush result", 160'(bus.alu_result_o), 160'(0));
        idle_watch("done flush");

        @(posedge clk);
        #1;
        drive(1'b1, 2'd2, 4'd4, 32'hFFFF_FFF9, 32'd2);
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("reset mid-op outputs", outs(), 160'(0));
        @(negedge clk);
        drive(1'b0, 2'd0, 4'd0, '0, '0);
        rst_n = 1'b1;
        run_op("divu after reset", 2'd2, 4'd5, 32'd9, 32'd3, 32'd3);

        for (int i = 0; i < 40; i++) begin
            logic [1:0] s;
            logic [3:0] o;
            word_t a, b;
            s = 2'($urandom_range(0, 3));
            o = (s == 2'd2) ? 4'($urandom_range(0, 8)) : 4'($urandom_range(0, 11));
            a = rnd_word();
            b = rnd_word();
            run_op($sformatf("rand%0d", i), s, o, a, b, ref_res(s, o, a, b));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
